// File: rtl/cdb_arbiter_if.sv
// FU-to-CDB handshake bundle: per-FU completion requests in, ready and CDB lanes out.
// The arbiter takes the slave view; the functional units (or a bench) take the master view.
interface cdb_arbiter_if #(
  parameter int unsigned FU_NUMBER = 4,
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned TAG_W     = 6
);

  logic [FU_NUMBER-1:0]            FU_complete_i;
  logic [FU_NUMBER-1:0][TAG_W-1:0] completed_tag_i;
  logic [FU_NUMBER-1:0]            FU_ready_o;
  logic [CDB_WIDTH-1:0]            CDB_en_o;
  logic [CDB_WIDTH-1:0][TAG_W-1:0] CDB_o;

  modport master (
    output FU_complete_i,
    output completed_tag_i,
    input  FU_ready_o,
    input  CDB_en_o,
    input  CDB_o
  );

  modport slave (
    input  FU_complete_i,
    input  completed_tag_i,
    output FU_ready_o,
    output CDB_en_o,
    output CDB_o
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one holding slot per FU, up to CDB_WIDTH tags broadcast per
// cycle in rotating priority starting at rr_ptr, lanes packed from lane 0.
module cdb_arbiter #(
  parameter int unsigned FU_NUMBER   = 4,
  parameter int unsigned CDB_WIDTH   = 2,
  parameter int unsigned PREG_NUMBER = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  cdb_arbiter_if.slave cdb
);

  localparam int unsigned TAG_W  = $clog2(PREG_NUMBER);
  localparam int unsigned PTR_W  = (FU_NUMBER > 1) ? $clog2(FU_NUMBER) : 1;
  localparam int unsigned CNT_W  = $clog2(CDB_WIDTH + 1);
  localparam int unsigned LANE_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

  logic [FU_NUMBER-1:0]            slot_valid_q, slot_valid_d;
  logic [FU_NUMBER-1:0][TAG_W-1:0] slot_tag_q, slot_tag_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;

  logic [FU_NUMBER-1:0]            grant_c;
  logic [FU_NUMBER-1:0]            ready_c;
  logic [CDB_WIDTH-1:0]            lane_en_c;
  logic [CDB_WIDTH-1:0][TAG_W-1:0] lane_tag_c;
  logic [PTR_W-1:0]                last_fu_c;

  // Priority scan from rr_ptr; the k-th valid slot found drives lane k.
  always_comb begin : grant_scan
    logic [CNT_W-1:0] n_granted;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    grant_c    = '0;
    lane_en_c  = '0;
    lane_tag_c = '0;
    last_fu_c  = rr_ptr_q;
    n_granted  = '0;
    sum        = '0;
    idx        = '0;
    for (int unsigned off = 0; off < FU_NUMBER; off++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(FU_NUMBER)) begin
        sum = sum - (PTR_W+1)'(FU_NUMBER);
      end
      idx = sum[PTR_W-1:0];
      if (slot_valid_q[idx] && (n_granted < CNT_W'(CDB_WIDTH))) begin
        grant_c[idx]                         = 1'b1;
        lane_en_c[n_granted[LANE_W-1:0]]     = 1'b1;
        lane_tag_c[n_granted[LANE_W-1:0]]    = slot_tag_q[idx];
        last_fu_c                            = idx;
        n_granted                            = n_granted + CNT_W'(1);
      end
    end
  end

  // A granted slot frees up this cycle, so it may accept a new completion at the same edge.
  always_comb begin : handshake
    ready_c = '0;
    if (!flush_i) begin
      ready_c = ~slot_valid_q | grant_c;
    end
  end

  // Flush squashes both the broadcast and any capture in the same cycle.
  always_comb begin : cdb_drive
    cdb.CDB_en_o   = '0;
    cdb.CDB_o      = '0;
    cdb.FU_ready_o = ready_c;
    if (!flush_i) begin
      cdb.CDB_en_o = lane_en_c;
      cdb.CDB_o    = lane_tag_c;
    end
  end

  always_comb begin : next_state
    slot_valid_d = slot_valid_q;
    slot_tag_d   = slot_tag_q;
    rr_ptr_d     = rr_ptr_q;
    if (flush_i) begin
      slot_valid_d = '0;
      rr_ptr_d     = '0;
    end else begin
      for (int unsigned i = 0; i < FU_NUMBER; i++) begin
        if (cdb.FU_complete_i[i] && ready_c[i]) begin
          slot_valid_d[i] = 1'b1;
          slot_tag_d[i]   = cdb.completed_tag_i[i];
        end else if (grant_c[i]) begin
          slot_valid_d[i] = 1'b0;
        end
      end
      // Next priority goes to the FU just after the last one served.
      if (|grant_c) begin
        if (last_fu_c == PTR_W'(FU_NUMBER - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = last_fu_c + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      slot_valid_q <= '0;
      slot_tag_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_tag_q   <= slot_tag_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-based round-robin model is checked every cycle,
// with hand-computed literals at the key points of each scenario.
module tb_cdb_arbiter;

  localparam int unsigned FUN = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned PN  = 64;
  localparam int unsigned TW  = 6;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  cdb_arbiter_if #(.FU_NUMBER(FUN), .CDB_WIDTH(CW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.FU_NUMBER(FUN), .CDB_WIDTH(CW), .PREG_NUMBER(PN)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .cdb     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending tags per FU, and the FU index that has top priority.
  bit m_valid[FUN];
  int m_tag[FUN];
  int m_ptr;
  bit m_grant[FUN];
  int m_lane_fu[CW];
  int m_n;

  // Walk FUs in priority order, queue the pending ones, serve the first CW of them.
  function automatic void m_arbitrate();
    int q[$];
    for (int k = 0; k < FUN; k++) begin
      if (m_valid[(m_ptr + k) % FUN]) q.push_back((m_ptr + k) % FUN);
    end
    m_n = (q.size() < CW) ? q.size() : CW;
    for (int i = 0; i < FUN; i++) m_grant[i] = 1'b0;
    for (int k = 0; k < CW; k++) m_lane_fu[k] = -1;
    for (int k = 0; k < m_n; k++) begin
      m_lane_fu[k]    = q[k];
      m_grant[q[k]]   = 1'b1;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FUN; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i]   = 0;
      end
      m_ptr = 0;
    end else if (flush) begin
      for (int i = 0; i < FUN; i++) m_valid[i] = 1'b0;
      m_ptr = 0;
    end else begin
      bit was_valid[FUN];
      m_arbitrate();
      for (int i = 0; i < FUN; i++) was_valid[i] = m_valid[i];
      for (int i = 0; i < FUN; i++) begin
        if (bus.FU_complete_i[i] && (!was_valid[i] || m_grant[i])) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = int'(bus.completed_tag_i[i]);
        end else if (m_grant[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (m_n > 0) m_ptr = (m_lane_fu[m_n-1] + 1) % FUN;
    end
  end

  always @(negedge clk) begin
    logic [CW-1:0]  exp_en;
    logic [FUN-1:0] exp_rdy;
    int             exp_tag;
    m_arbitrate();
    exp_en  = '0;
    exp_rdy = '0;
    for (int k = 0; k < CW; k++) begin
      exp_tag = 0;
      if (!flush && k < m_n) begin
        exp_en[k] = 1'b1;
        exp_tag   = m_tag[m_lane_fu[k]];
      end
      check($sformatf("lane%0d_tag", k), 32'(bus.CDB_o[k]), 32'(exp_tag));
    end
    for (int i = 0; i < FUN; i++) exp_rdy[i] = !flush && (!m_valid[i] || m_grant[i]);
    check("cdb_en", 32'(bus.CDB_en_o), 32'(exp_en));
    check("fu_ready", 32'(bus.FU_ready_o), 32'(exp_rdy));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.FU_complete_i   = '0;
    bus.completed_tag_i = '0;
  endtask

  initial begin
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    // 1. reset values
    check("rst_en", 32'(bus.CDB_en_o), 32'h0);
    check("rst_tags", 32'(bus.CDB_o), 32'h0);
    check("rst_ready", 32'(bus.FU_ready_o), 32'hF);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_en", 32'(bus.CDB_en_o), 32'h0);
    check("post_rst_ready", 32'(bus.FU_ready_o), 32'hF);

    // 2. single completion on FU2
    tick();
    bus.FU_complete_i[2]   = 1'b1;
    bus.completed_tag_i[2] = 6'd17;
    tick();
    idle_inputs();
    #1;
    check("t2_en", 32'(bus.CDB_en_o), 32'h1);
    check("t2_lane0", 32'(bus.CDB_o[0]), 32'd17);
    check("t2_lane1", 32'(bus.CDB_o[1]), 32'd0);
    tick();
    check("t2_en_after", 32'(bus.CDB_en_o), 32'h0);
    check("t2_model_ptr", 32'(m_ptr), 32'd3);

    // 4. wrap order from rr_ptr=3: FU3 takes lane 0, FU0 lane 1
    bus.FU_complete_i[0]   = 1'b1;
    bus.completed_tag_i[0] = 6'd5;
    bus.FU_complete_i[3]   = 1'b1;
    bus.completed_tag_i[3] = 6'd40;
    tick();
    idle_inputs();
    #1;
    check("t4_en", 32'(bus.CDB_en_o), 32'h3);
    check("t4_lane0", 32'(bus.CDB_o[0]), 32'd40);
    check("t4_lane1", 32'(bus.CDB_o[1]), 32'd5);
    tick();
    check("t4_model_ptr", 32'(m_ptr), 32'd1);

    // bring rr_ptr back to 0 via a lone FU3 grant
    bus.FU_complete_i[3]   = 1'b1;
    bus.completed_tag_i[3] = 6'd0;
    tick();
    idle_inputs();
    #1;
    check("tag0_en", 32'(bus.CDB_en_o), 32'h1);
    check("tag0_lane0", 32'(bus.CDB_o[0]), 32'd0);
    tick();
    check("t3_model_ptr0", 32'(m_ptr), 32'd0);

    // 3. all four FUs complete at rr_ptr=0
    bus.FU_complete_i = 4'hF;
    for (int i = 0; i < FUN; i++) bus.completed_tag_i[i] = 6'(10 + i);
    tick();
    idle_inputs();
    #1;
    check("t3_c1_en", 32'(bus.CDB_en_o), 32'h3);
    check("t3_c1_lane0", 32'(bus.CDB_o[0]), 32'd10);
    check("t3_c1_lane1", 32'(bus.CDB_o[1]), 32'd11);
    check("t3_c1_ready", 32'(bus.FU_ready_o), 32'h3);
    tick();
    check("t3_c2_lane0", 32'(bus.CDB_o[0]), 32'd12);
    check("t3_c2_lane1", 32'(bus.CDB_o[1]), 32'd13);
    tick();
    check("t3_c3_en", 32'(bus.CDB_en_o), 32'h0);
    check("t3_model_ptr", 32'(m_ptr), 32'd0);

    // 5. backpressure: move rr_ptr to 2, then FU1 loses to FU2/FU3
    bus.FU_complete_i[1]   = 1'b1;
    bus.completed_tag_i[1] = 6'd50;
    tick();
    idle_inputs();
    tick();
    check("t5_model_ptr", 32'(m_ptr), 32'd2);
    bus.FU_complete_i      = 4'b1110;
    bus.completed_tag_i[1] = 6'd7;
    bus.completed_tag_i[2] = 6'd20;
    bus.completed_tag_i[3] = 6'd30;
    tick();
    bus.FU_complete_i      = 4'b0010;
    bus.completed_tag_i    = '0;
    bus.completed_tag_i[1] = 6'd9;
    #1;
    check("t5_ready", 32'(bus.FU_ready_o), 32'hD);
    check("t5_lane0", 32'(bus.CDB_o[0]), 32'd20);
    check("t5_lane1", 32'(bus.CDB_o[1]), 32'd30);
    tick();
    idle_inputs();
    #1;
    check("t5_hold_en", 32'(bus.CDB_en_o), 32'h1);
    check("t5_hold_tag", 32'(bus.CDB_o[0]), 32'd7);
    tick();
    check("t5_drain_en", 32'(bus.CDB_en_o), 32'h0);

    // 6. flush with FU0..FU2 pending
    bus.FU_complete_i = 4'b0111;
    for (int i = 0; i < 3; i++) bus.completed_tag_i[i] = 6'(1 + i);
    tick();
    idle_inputs();
    flush = 1'b1;
    bus.FU_complete_i[3]   = 1'b1;
    bus.completed_tag_i[3] = 6'd63;
    #1;
    check("t6_flush_en", 32'(bus.CDB_en_o), 32'h0);
    check("t6_flush_tags", 32'(bus.CDB_o), 32'h0);
    check("t6_flush_ready", 32'(bus.FU_ready_o), 32'h0);
    tick();
    flush = 1'b0;
    idle_inputs();
    #1;
    check("t6_post_en", 32'(bus.CDB_en_o), 32'h0);
    check("t6_post_ready", 32'(bus.FU_ready_o), 32'hF);
    check("t6_model_ptr", 32'(m_ptr), 32'd0);

    // after flush priority restarts at FU0
    bus.FU_complete_i      = 4'b1001;
    bus.completed_tag_i[0] = 6'd33;
    bus.completed_tag_i[3] = 6'd44;
    tick();
    idle_inputs();
    #1;
    check("t6_order_lane0", 32'(bus.CDB_o[0]), 32'd33);
    check("t6_order_lane1", 32'(bus.CDB_o[1]), 32'd44);
    tick();

    // reset between edges drops a pending slot without broadcasting it
    bus.FU_complete_i[0]   = 1'b1;
    bus.completed_tag_i[0] = 6'd8;
    tick();
    idle_inputs();
    #1;
    check("ar_pre_en", 32'(bus.CDB_en_o), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("ar_en", 32'(bus.CDB_en_o), 32'h0);
    check("ar_tags", 32'(bus.CDB_o), 32'h0);
    check("ar_ready", 32'(bus.FU_ready_o), 32'hF);
    tick();
    reset = 1'b0;
    tick();
    check("ar_after_en", 32'(bus.CDB_en_o), 32'h0);

    // sustained directed traffic with periodic flushes
    for (int c = 0; c < 60; c++) begin
      bus.FU_complete_i = 4'((c * 7 + 3) ^ (c >> 2));
      for (int i = 0; i < FUN; i++) bus.completed_tag_i[i] = 6'(c * 4 + i);
      flush = ((c % 13) == 12);
      tick();
    end
    idle_inputs();
    flush = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter and completion buffer in front of the common data bus.
- Each functional unit gets a one-entry holding slot for its completed destination tag.
- Each cycle up to CDB_WIDTH pending tags are granted onto the CDB lanes, in rotating-priority order, so no FU starves.
- FUs see a ready/valid handshake and stall while their slot is occupied and not granted.

Parameters:
- FU_NUMBER, 4, number of requesting functional units.
- CDB_WIDTH, 2, number of CDB broadcast lanes per cycle.
- PREG_NUMBER, 64, physical register count; TAG_W = $clog2(PREG_NUMBER).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush_i  input  1  synchronous squash of every pending slot (branch mispredict).
- FU_complete_i  input  FU_NUMBER  per-FU completion valid.
- completed_tag_i  input  FU_NUMBER x TAG_W  per-FU destination physical tag.
- FU_ready_o  output  FU_NUMBER  per-FU ready; a completion is accepted when valid and ready are both high at posedge.
- CDB_en_o  output  CDB_WIDTH  lane valid.
- CDB_o  output  CDB_WIDTH x TAG_W  lane tag.

Behaviour:
- State:
  - per-FU slot_valid and slot_tag;
  - rr_ptr of $clog2(FU_NUMBER) bits, the highest-priority FU index.
- Reset, asynchronous and taking effect immediately:
  - slot_valid = 0, slot_tag = 0, rr_ptr = 0;
  - outputs therefore CDB_en_o = 0, CDB_o = 0, FU_ready_o = all ones.
- Grant selection (combinational from registered slots):
  - scan FU indices rr_ptr, rr_ptr+1, ... modulo FU_NUMBER;
  - the first CDB_WIDTH valid slots found are granted;
  - the k-th grant drives lane k, so lanes fill from lane 0 with no gaps.
- Unused lanes: CDB_en_o bit = 0 and CDB_o = 0.
- Handshake: FU_ready_o[i] = ~slot_valid[i] | grant[i].
  - A granted slot may reload in the same edge, giving one completion per FU per cycle sustained.
- Capture at posedge (when FU_complete_i[i] & FU_ready_o[i]):
  - slot_valid[i] = 1, slot_tag[i] = completed_tag_i[i].
  - Otherwise a granted slot clears and an ungranted valid slot holds its tag unchanged.
- Latency: a tag accepted at edge N is broadcast no earlier than the cycle following edge N. There is no combinational path from FU_complete_i to CDB outputs.
- Pointer update:
  - if any grant occurs, rr_ptr = (index of last granted FU + 1) mod FU_NUMBER;
  - else rr_ptr is unchanged.
  - Worst-case wait for a valid slot is ceil(FU_NUMBER / CDB_WIDTH) cycles.
- flush_i high:
  - in that cycle CDB_en_o = 0, CDB_o = 0 and FU_ready_o = 0, so no capture happens;
  - at the edge all slot_valid = 0 and rr_ptr = 0.
  - flush has priority over grants and captures.
- Reset asserted mid-operation discards pending slots with no broadcast. Outputs return to their reset values without waiting for a clock edge.
- Tag value 0 is a legal tag; validity is carried only by the enable bits.
- Fewer valid slots than lanes: only the low lanes are used (e.g. one valid gives CDB_en_o = 2'b01).

Test Plan (FU_NUMBER=4, CDB_WIDTH=2, TAG_W=6):
1. Assert reset, then release with no completions -> CDB_en_o=2'b00, CDB_o=0/0, FU_ready_o=4'b1111; state is also cleared asynchronously when reset rises between edges.
2. FU2 completes tag 17 for one cycle -> next cycle CDB_en_o=2'b01, CDB_o[0]=17, CDB_o[1]=0; the cycle after, CDB_en_o=2'b00; rr_ptr=3.
3. All FUs complete tags 10,11,12,13 at rr_ptr=0:
   - cycle 1: lanes 10/11, FU_ready_o=4'b0011;
   - cycle 2: lanes 12/13;
   - rr_ptr ends at 0.
4. Wrap order: rr_ptr=3, slots FU0 (tag 5) and FU3 (tag 40) valid -> CDB_o[0]=40, CDB_o[1]=5, CDB_en_o=2'b11; rr_ptr becomes 1.
5. Backpressure: FU1 holds tag 7 while higher-priority FU2/FU3 take both lanes; FU1 asserts tag 9 -> FU_ready_o[1]=0, tag 9 is not captured, and tag 7 is broadcast in the next cycle.
6. Slots FU0/FU1/FU2 valid and flush_i pulsed for one cycle -> in that cycle CDB_en_o=2'b00 and FU_ready_o=4'b0000; the next cycle has no enables, FU_ready_o=4'b1111 and rr_ptr=0.
